// File: rtl/apb_pkg.sv
// Shared APB definitions used by the completer register file and the
// master transactor: completer FSM state encoding, protection and
// wait-counter widths, and the byte-strobe merge helper.
package apb_pkg;

  localparam int APB_PROT_W = 3;
  localparam int APB_CNT_W  = 4;

  typedef enum logic [0:0] {
    CPL_IDLE   = 1'b0,
    CPL_ACCESS = 1'b1
  } cpl_state_e;

  // Replace only the bytes whose strobe bit is set.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_completer_regfile_if.sv
// APB4 bus bundle between a master and a completer.
// master modport drives psel/penable/pwrite/paddr/pwdata/pstrb/pprot and
// observes pready/prdata/pslverr; slave modport is the mirror image.
interface apb_completer_regfile_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [APB_PROT_W-1:0] pprot;
  logic                  pready;
  logic [DATA_W-1:0]     prdata;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_reg_bank.sv
// Register storage behind the APB completer.
// Ports: clk/rst (async, active-low); we_i/idx_i/wdata_i/strb_i write
// request; regs_o flattened contents (reg 0 is the constant ID word);
// rdata_o word selected by idx_i; wr_pulse_o one-cycle pulse per committed
// write, aligned with the cycle after the write edge.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = 32'hA9B0_0001,
  localparam int         IDX_W    = $clog2(NUM_REGS),
  localparam int         STRB_W   = DATA_W / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we_i,
  input  logic [IDX_W-1:0]           idx_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [STRB_W-1:0]          strb_i,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pulse_q;

  // Entry 0 is never written; the ID constant is presented in its place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (we_i && idx_i == IDX_W'(i)) begin
          regs_q[i]  <= strb_merge(regs_q[i], wdata_i, strb_i);
          pulse_q[i] <= 1'b1;
        end
      end
    end
  end

  assign regs_o[0 +: DATA_W] = ID_VALUE;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_i == IDX_W'(i)) rdata_o = regs_o[i*DATA_W +: DATA_W];
    end
  end

  assign wr_pulse_o = pulse_q;

endmodule

// File: rtl/apb_completer_regfile.sv
// APB4 completer terminating transfers into a small register file.
// Ports: clk, rst (async, active-low); apb slave modport (psel, penable,
// pwrite, paddr, pwdata, pstrb, pprot in; pready, prdata, pslverr out);
// regs_o flattened register contents, reg i at [i*32 +: 32];
// wr_pulse_o one-cycle pulse per register on a committed write.
// Register 0 is a read-only ID word; writes to it, misaligned addresses
// and addresses beyond the file return pslverr with no side effect.
module apb_completer_regfile
  import apb_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 32,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                       clk,
  input  logic                       rst,
  apb_completer_regfile_if.slave     apb,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(NUM_REGS);

  localparam logic [0:0] S_IDLE   = 1'(CPL_IDLE);
  localparam logic [0:0] S_ACCESS = 1'(CPL_ACCESS);

  logic [0:0]            state_q, state_d;
  logic [APB_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q;
  logic                  write_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [STRB_W-1:0]     strb_q;
  logic [APB_PROT_W-1:0] prot_q;
  logic                  prot_unused;

  logic                  load;
  logic                  ready;
  logic                  err;
  logic                  we;
  logic [IDX_W-1:0]      idx;
  logic [DATA_W-1:0]     rdata;

  // Decode from the latched request only, so pready/pslverr/prdata have no
  // combinational path from the bus inputs.
  assign idx   = addr_q[2 +: IDX_W];
  assign err   = (addr_q[1:0] != 2'b00) |
                 (addr_q >= ADDR_W'(NUM_REGS * 4)) |
                 (write_q & (idx == '0));
  assign ready = (state_q == S_ACCESS) && (cnt_q == '0);
  assign load  = (state_q == S_IDLE) & apb.psel & ~apb.penable;
  assign we    = ready & apb.psel & apb.penable & write_q & ~err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // psel with penable already high is a protocol violation: ignored.
        if (load) begin
          state_d = S_ACCESS;
          cnt_d   = APB_CNT_W'(WAIT_CYCLES);
        end
      end
      default: begin
        if (!apb.psel) begin
          state_d = S_IDLE;
        end else if (apb.penable && ready) begin
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture at the setup edge.
  always_ff @(posedge clk) begin
    if (load) begin
      addr_q  <= apb.paddr;
      write_q <= apb.pwrite;
      wdata_q <= apb.pwdata;
      strb_q  <= apb.pstrb;
      prot_q  <= apb.pprot;
    end
  end

  // pprot is held for future access checks; nothing consumes it yet.
  assign prot_unused = ^prot_q;

  apb_reg_bank #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .we_i       (we),
    .idx_i      (idx),
    .wdata_i    (wdata_q),
    .strb_i     (strb_q),
    .regs_o     (regs_o),
    .rdata_o    (rdata),
    .wr_pulse_o (wr_pulse_o)
  );

  assign apb.pready  = ready;
  assign apb.pslverr = ready & err;
  assign apb.prdata  = (ready & ~write_q & ~err) ? rdata : '0;

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Bench for apb_completer_regfile: two instances (0 and 3 wait states)
// share one stimulus bus; only the selected instance sees psel.
module tb_apb_completer_regfile;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int          dsel = 0;
  logic        m_psel = 1'b0, m_penable = 1'b0, m_pwrite = 1'b0;
  logic [31:0] m_paddr = '0, m_pwdata = '0;
  logic [3:0]  m_pstrb = '0;
  logic [2:0]  m_pprot = '0;

  apb_completer_regfile_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
  apb_completer_regfile_if #(.ADDR_W(32), .DATA_W(32)) if3 ();

  assign if0.psel = m_psel & (dsel == 0);
  assign if3.psel = m_psel & (dsel == 1);
  assign if0.penable = m_penable;  assign if3.penable = m_penable;
  assign if0.pwrite  = m_pwrite;   assign if3.pwrite  = m_pwrite;
  assign if0.paddr   = m_paddr;    assign if3.paddr   = m_paddr;
  assign if0.pwdata  = m_pwdata;   assign if3.pwdata  = m_pwdata;
  assign if0.pstrb   = m_pstrb;    assign if3.pstrb   = m_pstrb;
  assign if0.pprot   = m_pprot;    assign if3.pprot   = m_pprot;

  logic [255:0] regs0, regs3;
  logic [7:0]   pulse0, pulse3;

  apb_completer_regfile #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .apb(if0.slave), .regs_o(regs0), .wr_pulse_o(pulse0));
  apb_completer_regfile #(.WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .apb(if3.slave), .regs_o(regs3), .wr_pulse_o(pulse3));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A transfer is "open" from its setup edge; it is ready once it has
  // spent W access cycles. Registers are a plain array per instance.
  int          W [2] = '{0, 3};
  bit          busy [2];
  int          age [2];
  logic        lw [2];
  logic [31:0] la [2], ld [2];
  logic [3:0]  ls [2];
  logic [31:0] mreg [2][8];
  logic [7:0]  mpulse [2];

  function automatic bit merr(input logic [31:0] a, input logic wr);
    return (a % 4 != 0) || (a >= 32) || (wr && (a / 4 == 0));
  endfunction

  function automatic logic [255:0] mflat(input int d);
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = mreg[d][i];
    return f;
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        busy[d] = 0; age[d] = 0; mpulse[d] = '0;
        mreg[d][0] = ID;
        for (int i = 1; i < 8; i++) mreg[d][i] = '0;
      end else begin
        logic ps;
        logic [7:0] pn;
        int r;
        pn = '0;
        ps = (d == 0) ? if0.psel : if3.psel;
        if (busy[d]) begin
          if (!ps) busy[d] = 0;
          else if (m_penable && age[d] >= W[d]) begin
            if (lw[d] && !merr(la[d], lw[d])) begin
              r = int'(la[d] / 4);
              for (int b = 0; b < 4; b++)
                if (ls[d][b]) mreg[d][r][8*b +: 8] = ld[d][8*b +: 8];
              pn[r] = 1'b1;
            end
            busy[d] = 0;
          end else age[d]++;
        end else if (ps && !m_penable) begin
          busy[d] = 1; age[d] = 0;
          lw[d] = m_pwrite; la[d] = m_paddr; ld[d] = m_pwdata; ls[d] = m_pstrb;
        end
        mpulse[d] = pn;
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic rdy, e;
      logic [31:0] erd;
      rdy = busy[d] && (age[d] >= W[d]);
      e   = merr(la[d], lw[d]);
      erd = '0;
      if (rdy && !lw[d] && !e) erd = mreg[d][la[d] / 4];
      chk($sformatf("pready_w%0d", W[d]),  (d == 0) ? if0.pready  : if3.pready,  rdy);
      chk($sformatf("pslverr_w%0d", W[d]), (d == 0) ? if0.pslverr : if3.pslverr, rdy && e);
      chk($sformatf("prdata_w%0d", W[d]),  (d == 0) ? if0.prdata  : if3.prdata,  erd);
      chk($sformatf("pulse_w%0d", W[d]),   (d == 0) ? pulse0      : pulse3,      mpulse[d]);
      chk($sformatf("regs_w%0d", W[d]),    (d == 0) ? regs0       : regs3,       mflat(d));
    end
  end

  // ---------------- stimulus ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  // One complete transfer; called just after a rising edge.
  task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd, output logic er, output int waits);
    bit got;
    dsel = d; m_psel = 1; m_penable = 0; m_pwrite = wr;
    m_paddr = a; m_pwdata = wd; m_pstrb = st; m_pprot = 3'b010;
    sync();
    m_penable = 1; waits = 0; got = 0; rd = '0; er = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((d == 0) ? if0.pready : if3.pready) begin got = 1; break; end
      waits++;
    end
    if (!got) chk("xfer_timeout", 0, 1);
    rd = (d == 0) ? if0.prdata : if3.prdata;
    er = (d == 0) ? if0.pslverr : if3.pslverr;
    sync();
    m_psel = 0; m_penable = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int wt;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pready", if0.pready, 0);
    chk("reset_regs", regs3, 256'(ID));
    sync(); rst = 1; sync();

    // ID read, minimum two-cycle transfer
    xfer(0, 0, 32'h0, 0, 4'h0, rd, er, wt);
    chk("id_rdata", rd, 32'hA9B0_0001);
    chk("id_err", er, 0);
    chk("id_waits", wt, 0);

    // strobed write then read back
    xfer(0, 1, 32'h4, 32'hDEAD_BEEF, 4'b0101, rd, er, wt);
    @(negedge clk); chk("wr1_pulse_on", pulse0, 8'h02);
    @(negedge clk); chk("wr1_pulse_off", pulse0, 8'h00);
    sync();
    xfer(0, 0, 32'h4, 0, 4'h0, rd, er, wt);
    chk("rd1_rdata", rd, 32'h00AD_00EF);

    // three wait states
    xfer(1, 1, 32'h8, 32'h1234_5678, 4'hF, rd, er, wt);
    chk("w3_waits", wt, 3);
    chk("w3_reg2", regs3[95:64], 32'h1234_5678);

    // error responses
    xfer(0, 1, 32'h0, 32'hFFFF_FFFF, 4'hF, rd, er, wt);
    chk("err_id_write", er, 1);
    @(negedge clk); chk("err_id_nopulse", pulse0, 0);
    chk("err_id_intact", regs0[31:0], ID);
    sync();
    xfer(0, 0, 32'h20, 0, 4'h0, rd, er, wt);
    chk("err_range", er, 1); chk("err_range_rd", rd, 0);
    xfer(0, 0, 32'h6, 0, 4'h0, rd, er, wt);
    chk("err_misalign", er, 1); chk("err_misalign_rd", rd, 0);

    // back-to-back write/read, both instances
    xfer(0, 1, 32'hC, 32'hCAFE_F00D, 4'hF, rd, er, wt);
    xfer(0, 0, 32'hC, 0, 4'h0, rd, er, wt);
    chk("b2b_w0", rd, 32'hCAFE_F00D);
    xfer(1, 1, 32'hC, 32'h0BAD_CAFE, 4'b1100, rd, er, wt);
    xfer(1, 0, 32'hC, 0, 4'h0, rd, er, wt);
    chk("b2b_w3", rd, 32'h0BAD_0000);

    // master abort during wait states
    dsel = 1; m_psel = 1; m_penable = 0; m_pwrite = 1;
    m_paddr = 32'h10; m_pwdata = 32'h5555_5555; m_pstrb = 4'hF;
    sync(); m_penable = 1; sync();
    m_psel = 0; m_penable = 0; sync();
    @(negedge clk); chk("abort_nopulse", pulse3, 0);
    chk("abort_reg4", regs3[159:128], 0);
    sync();
    xfer(1, 0, 32'h10, 0, 4'h0, rd, er, wt);
    chk("abort_readback", rd, 0);

    // reset during access wait
    dsel = 1; m_psel = 1; m_penable = 0; m_pwrite = 1;
    m_paddr = 32'h14; m_pwdata = 32'hFFFF_FFFF; m_pstrb = 4'hF;
    sync(); m_penable = 1; sync();
    rst = 0;
    @(negedge clk);
    chk("rst_pready", if3.pready, 0);
    chk("rst_regs3", regs3, 256'(ID));
    chk("rst_regs0", regs0, 256'(ID));
    m_psel = 0; m_penable = 0;
    sync(); rst = 1; sync();
    xfer(1, 0, 32'h14, 0, 4'h0, rd, er, wt);
    chk("post_rst_rd", rd, 0); chk("post_rst_waits", wt, 3);
    xfer(1, 1, 32'h18, 32'hA5A5_A5A5, 4'b0011, rd, er, wt);
    xfer(1, 0, 32'h18, 0, 4'h0, rd, er, wt);
    chk("post_rst_wr", rd, 32'h0000_A5A5);
    chk("post_rst_err", er, 0);

    repeat (3) sync();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_completer_regfile.md
Name: apb_completer_regfile

Overview:
- APB4 completer (slave) terminating transfers issued by the team's APB master transactor.
- Backed by a small word-addressed register file with byte strobes, programmable wait states and error response.
- Sits at the far end of the APB segment; supplies register contents and write pulses to local logic.
- Register 0 is a read-only ID word; registers 1..NUM_REGS-1 are read/write.

Parameters:
- DATA_W, 32, APB data width (fixed at 32; pstrb width DATA_W/8).
- ADDR_W, 32, APB address width.
- NUM_REGS, 8, number of 32-bit registers (2..64).
- WAIT_CYCLES, 0, wait states inserted per access (0..15).
- ID_VALUE, 32'hA9B0_0001, constant returned by register 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- pwrite  in  1  1=write, 0=read
- paddr  in  ADDR_W  byte address
- pwdata  in  DATA_W  write data
- pstrb  in  DATA_W/8  write byte strobes
- pprot  in  3  protection (captured, not checked)
- pready  out  1  transfer completion
- prdata  out  DATA_W  read data, valid when pready=1
- pslverr  out  1  error response, valid when pready=1
- regs_o  out  NUM_REGS*DATA_W  flattened register contents, reg i at bits [i*32+:32]
- wr_pulse_o  out  NUM_REGS  one-cycle pulse per register on committed write

Behaviour:
- Reset (rst=0, any time, including mid-transfer): FSM to IDLE, wait counter 0, pready=0, pslverr=0, prdata=0, wr_pulse_o=0, regs 1..N-1=0, reg0 reads ID_VALUE. Any in-flight transfer is discarded with no write.
- FSM states: IDLE, ACCESS.
- IDLE:
  - pready=0, prdata=0, pslverr=0.
  - On a clk edge with psel=1 and penable=0 (setup phase): latch paddr, pwrite, pwdata, pstrb, pprot; load cnt=WAIT_CYCLES; go to ACCESS.
  - psel=1 with penable=1 while in IDLE is a protocol violation: ignore it and stay in IDLE.
- ACCESS:
  - pready = (cnt==0); it is a function of registered state only, with no combinational path from inputs.
  - While cnt!=0, decrement cnt each cycle.
  - At the edge where psel=1, penable=1 and pready=1: the transfer completes. Commit a write if one is pending and there is no error, then go to IDLE.
  - If psel=0 at any edge while in ACCESS (master abort): go to IDLE with no write and no pulse.
- Latency:
  - WAIT_CYCLES=0 gives the minimum APB transfer of two cycles (setup, access).
  - Each wait state adds exactly one cycle of pready=0 in the access phase.
  - A back-to-back setup phase in the cycle after completion is accepted (IDLE samples it).
- Decode, from latched address:
  - idx = paddr[2+:log2(NUM_REGS)].
  - err = (paddr[1:0]!=0) | (paddr >= NUM_REGS*4) | (pwrite & idx==0).
- Response when pready=1:
  - pslverr=err.
  - prdata = (read & ~err) ? reg[idx] : 0.
  - prdata is 0 for all writes.
- Write commit:
  - For each byte b with pstrb[b]=1, reg[idx][8b+:8] <= pwdata[8b+:8]; bytes with pstrb[b]=0 are unchanged.
  - pstrb=0 is a legal write that changes nothing, but wr_pulse_o[idx] still pulses.
  - wr_pulse_o[idx]=1 for exactly the cycle after the completion edge; on error no bits change and there is no pulse.
- pstrb is ignored on reads; pprot is captured for future use only.

Decomposition:
- apb_pkg (shared with the master transactor):
  - completer FSM enum {IDLE, ACCESS};
  - localparam APB_PROT_W=3;
  - function for byte-strobe merge;
  - localparam for wait-counter width (4).
- One sub-module, apb_reg_bank:
  - storage, strobe merge, ID register, wr_pulse generation;
  - inputs: we, idx, wdata, strb;
  - outputs: regs flat, rdata mux.
- The top holds the FSM, wait counter, decode and response.

Test Plan:
- Reset, then read 0x0 with WAIT_CYCLES=0 -> pready=1 in the second cycle, prdata=0xA9B00001, pslverr=0.
- Write 0x4 data 0xDEADBEEF pstrb=4'b0101, then read 0x4 -> prdata=0x00AD00EF; wr_pulse_o[1] high for one cycle.
- WAIT_CYCLES=3: write 0x8 -> exactly 3 access cycles with pready=0, completion on the 4th; regs_o[2] updated only after completion.
- Error cases -> pslverr=1, prdata=0, no register change, no pulse:
  - write 0x0 (read-only ID register);
  - read 0x20 with NUM_REGS=8 (out of range);
  - read 0x6 (misaligned).
- Back-to-back write 0xC then read 0xC with no idle cycle -> both complete, read returns the written value; then drop psel mid-wait (WAIT_CYCLES=3) -> FSM to IDLE, no write.
- Assert rst during the ACCESS wait -> pready=0, regs cleared, ID intact; the next transfer after reset release completes normally.
